// File: rtl/mouse_transmitter.sv
// Host-to-device PS/2 transmitter. It sends one command byte to the mouse.
// Sequence: hold the mouse clock low, pull data low for the start bit,
// release the clock, then shift out the data bits, parity and stop bit on
// falling edges generated by the device. It then samples the acknowledge bit,
// waits for the bus to go idle, and reports status on a one-cycle BYTE_SENT.
module mouse_transmitter #(
    parameter int CLK_HOLD_CYCLES    = 6000,
    parameter int DATA_SETUP_CYCLES  = 50,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int BIT_TIMEOUT        = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       CLK_MOUSE_OUT_EN,
    output logic       DATA_MOUSE_OUT,
    output logic       DATA_MOUSE_OUT_EN,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic [1:0] BYTE_ERROR_CODE
);

    // One shared counter covers the hold, setup and timeout intervals, so it
    // is sized for the largest of them.
    localparam int MAX_A   = (CLK_HOLD_CYCLES > DATA_SETUP_CYCLES) ? CLK_HOLD_CYCLES : DATA_SETUP_CYCLES;
    localparam int MAX_B   = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DATA_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD_CLK,
        S_PULL_DATA,
        S_RELEASE,
        S_SEND_BITS,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;

    // Command byte, its parity and the sampled acknowledge bit.
    logic [7:0] r_byte;
    logic       r_parity;
    logic       r_ack_err;

    // Pad synchronisers and clock edge history.
    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_dat_meta;
    logic r_dat_sync;

    // Registered outputs.
    logic       r_clk_en;
    logic       r_data_en;
    logic       r_busy;
    logic       r_byte_sent;
    logic [1:0] r_code;

    // Next-state values.
    state_t           w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [3:0]       w_idx_n;
    logic             w_data_en_n;
    logic [1:0]       w_code_n;
    logic             w_clk_en_n;
    logic             w_busy_n;
    logic             w_sent_n;
    logic             w_latch;
    logic             w_ack_load;

    logic w_clk_fall;
    logic w_bus_idle;

    assign w_clk_fall = r_clk_prev & ~r_clk_sync;
    assign w_bus_idle = r_clk_sync & r_dat_sync;

    assign CLK_MOUSE_OUT_EN  = r_clk_en;
    assign DATA_MOUSE_OUT    = 1'b0;
    assign DATA_MOUSE_OUT_EN = r_data_en;
    assign BUSY              = r_busy;
    assign BYTE_SENT         = r_byte_sent;
    assign BYTE_ERROR_CODE   = r_code;

    // Two-flop synchronisers on both pads plus previous clock for edge detection.
    // They reset to the idle (high) level so that reset never causes a false falling edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= CLK_MOUSE_IN;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= DATA_MOUSE_IN;
            r_dat_sync <= r_dat_meta;
        end
    end

    // State register, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_clk_en    <= 1'b0;
            r_data_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_sent <= 1'b0;
            r_code      <= 2'b00;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_idx       <= w_idx_n;
            r_clk_en    <= w_clk_en_n;
            r_data_en   <= w_data_en_n;
            r_busy      <= w_busy_n;
            r_byte_sent <= w_sent_n;
            r_code      <= w_code_n;
        end
    end

    // Command byte with its odd parity, and the acknowledge sample (datapath, no reset).
    always_ff @(posedge CLK) begin
        if (w_latch) begin
            r_byte   <= BYTE_TO_SEND;
            r_parity <= ~^BYTE_TO_SEND;
        end
        if (w_ack_load) begin
            r_ack_err <= r_dat_sync;
        end
    end

    // Next-state and next-output logic. Outputs are registered from the next state,
    // so each output lines up with the state it belongs to.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_idx_n     = r_idx;
        w_data_en_n = r_data_en;
        w_code_n    = r_code;
        w_latch     = 1'b0;
        w_ack_load  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_data_en_n = 1'b0;
                w_cnt_n     = '0;
                if (SEND_BYTE) begin
                    w_latch   = 1'b1;
                    w_idx_n   = '0;
                    w_state_n = S_HOLD_CLK;
                end
            end

            S_HOLD_CLK: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_n     = '0;
                    w_data_en_n = 1'b1;
                    w_state_n   = S_PULL_DATA;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_PULL_DATA: begin
                if (r_cnt == SETUP_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = S_RELEASE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_RELEASE: begin
                if (w_clk_fall) begin
                    w_data_en_n = ~r_byte[0];
                    w_idx_n     = 4'd1;
                    w_cnt_n     = '0;
                    w_state_n   = S_SEND_BITS;
                end else if (r_cnt == FIRST_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = S_ABORT;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_SEND_BITS: begin
                if (w_clk_fall) begin
                    w_cnt_n = '0;
                    if (r_idx == 4'd9) begin
                        // Stop bit is always a released line.
                        w_data_en_n = 1'b0;
                        w_state_n   = S_WAIT_ACK;
                    end else if (r_idx == 4'd8) begin
                        w_data_en_n = ~r_parity;
                        w_idx_n     = r_idx + 4'd1;
                    end else begin
                        w_data_en_n = ~r_byte[r_idx[2:0]];
                        w_idx_n     = r_idx + 4'd1;
                    end
                end else if (r_cnt == BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = S_ABORT;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_WAIT_ACK: begin
                w_data_en_n = 1'b0;
                if (w_clk_fall) begin
                    w_ack_load = 1'b1;
                    w_cnt_n    = '0;
                    w_state_n  = S_WAIT_IDLE;
                end else if (r_cnt == BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = S_ABORT;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                w_data_en_n = 1'b0;
                if (w_bus_idle) begin
                    w_cnt_n   = '0;
                    w_code_n  = {1'b0, r_ack_err};
                    w_state_n = S_DONE;
                end else if (r_cnt == BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = S_ABORT;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_data_en_n = 1'b0;
                w_cnt_n     = '0;
                w_state_n   = S_IDLE;
            end

            S_ABORT: begin
                w_data_en_n = 1'b0;
                w_cnt_n     = '0;
                w_state_n   = S_IDLE;
            end

            default: begin
                w_data_en_n = 1'b0;
                w_cnt_n     = '0;
                w_state_n   = S_IDLE;
            end
        endcase

        if (w_state_n == S_ABORT) begin
            w_data_en_n = 1'b0;
            w_code_n    = CODE_TIMEOUT;
        end

        w_clk_en_n = (w_state_n == S_HOLD_CLK) || (w_state_n == S_PULL_DATA);
        w_busy_n   = (w_state_n != S_IDLE);
        w_sent_n   = (w_state_n == S_DONE) || (w_state_n == S_ABORT);
    end

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: a behavioural PS/2 mouse on a wired-AND bus,
// with expected frames, codes and timings computed from the protocol rules.
module tb_mouse_transmitter;

    localparam int HOLD  = 40;
    localparam int SETUP = 8;
    localparam int FET   = 400;
    localparam int BT    = 150;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_STALL  = 3;
    localparam int M_RESET  = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE = 1'b0;
    logic [7:0] BYTE_TO_SEND = 8'h00;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       CLK_MOUSE_OUT_EN;
    logic       DATA_MOUSE_OUT;
    logic       DATA_MOUSE_OUT_EN;
    logic       BUSY;
    logic       BYTE_SENT;
    logic [1:0] BYTE_ERROR_CODE;

    // Mouse-side drivers; 1 = released.
    logic m_clk = 1'b1;
    logic m_dat = 1'b1;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int sent_pulses = 0;

    mouse_transmitter #(
        .CLK_HOLD_CYCLES   (HOLD),
        .DATA_SETUP_CYCLES (SETUP),
        .FIRST_EDGE_TIMEOUT(FET),
        .BIT_TIMEOUT       (BT)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .CLK_MOUSE_IN     (CLK_MOUSE_IN),
        .DATA_MOUSE_IN    (DATA_MOUSE_IN),
        .SEND_BYTE        (SEND_BYTE),
        .BYTE_TO_SEND     (BYTE_TO_SEND),
        .CLK_MOUSE_OUT_EN (CLK_MOUSE_OUT_EN),
        .DATA_MOUSE_OUT   (DATA_MOUSE_OUT),
        .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
        .BUSY             (BUSY),
        .BYTE_SENT        (BYTE_SENT),
        .BYTE_ERROR_CODE  (BYTE_ERROR_CODE)
    );

    // Open-drain bus: either side can pull a line low.
    assign CLK_MOUSE_IN  = m_clk & ~CLK_MOUSE_OUT_EN;
    assign DATA_MOUSE_IN = m_dat & (DATA_MOUSE_OUT_EN ? DATA_MOUSE_OUT : 1'b1);

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) if (BYTE_SENT) sent_pulses <= sent_pulses + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line samples: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_done(input int budget, output bit ok, output logic [1:0] code, output int dcyc);
        int t;
        ok = 1'b0;
        code = 2'b11;
        dcyc = 0;
        t = 0;
        while (!ok && t < budget) begin
            @(negedge CLK);
            t++;
            if (BYTE_SENT === 1'b1) begin
                ok = 1'b1;
                code = BYTE_ERROR_CODE;
                dcyc = cyc;
            end
        end
    endtask

    task automatic issue_send(input logic [7:0] b);
        @(negedge CLK);
        BYTE_TO_SEND = b;
        SEND_BYTE = 1'b1;
        @(negedge CLK);
        SEND_BYTE = 1'b0;
        BYTE_TO_SEND = ~b;
    endtask

    // Plays the mouse for one frame. When chain is set, a new request with
    // next_b is raised in the BYTE_SENT cycle and held one more cycle.
    task automatic run_frame(input logic [7:0] b, input int mode, input int n_falls, input int half,
                             input bit chain, input logic [7:0] next_b);
        int t, hold, setup, rel_cyc, last_fall, dcyc, n;
        bit ok;
        logic [1:0] code;
        logic [10:0] got, exp_f, mask;
        exp_f = model_frame(b);
        got = '1;
        last_fall = 0;

        t = 0;
        while (CLK_MOUSE_OUT_EN !== 1'b1 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        hold = 0;
        while (CLK_MOUSE_OUT_EN === 1'b1 && DATA_MOUSE_OUT_EN === 1'b0 && hold < HOLD + 20) begin
            hold++;
            @(negedge CLK);
        end
        check_val("hold_cycles", hold, HOLD);
        setup = 0;
        while (CLK_MOUSE_OUT_EN === 1'b1 && DATA_MOUSE_OUT_EN === 1'b1 && setup < SETUP + 20) begin
            setup++;
            @(negedge CLK);
        end
        check_val("setup_cycles", setup, SETUP);
        check_val("release_lines", {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT}, 3'b010);
        rel_cyc = cyc;

        if (mode == M_SILENT) begin
            wait_done(FET + 40, ok, code, dcyc);
            check_val("silent_done_seen", ok, 1);
            check_val("silent_code", code, 2'b10);
            check_val("silent_timeout_cycles", dcyc - rel_cyc, FET);
            check_val("silent_lines", {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 2'b00);
            return;
        end

        n = (mode == M_ACK || mode == M_NOACK) ? 11 : n_falls;
        for (int k = 0; k < n; k++) begin
            wait_cycles(half);
            got[k] = DATA_MOUSE_IN;
            if (k == 10 && mode == M_ACK) m_dat = 1'b0;
            wait_cycles(2);
            m_clk = 1'b0;
            last_fall = cyc;
            if (mode == M_STALL && k == 1) begin
                BYTE_TO_SEND = 8'h00;
                SEND_BYTE = 1'b1;
                wait_cycles(1);
                SEND_BYTE = 1'b0;
                wait_cycles(half - 1);
            end else begin
                wait_cycles(half);
            end
            m_clk = 1'b1;
            m_dat = 1'b1;
        end

        if (mode == M_ACK || mode == M_NOACK) begin
            wait_done(60, ok, code, dcyc);
            check_val("done_seen", ok, 1);
            check_val("done_code", code, (mode == M_ACK) ? 2'b00 : 2'b01);
            check_val("frame_bits", got, exp_f);
            if (chain) begin
                BYTE_TO_SEND = next_b;
                SEND_BYTE = 1'b1;
            end
            @(negedge CLK);
            check_val("idle_after_done", {BUSY, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 3'b000);
            check_val("code_held", BYTE_ERROR_CODE, (mode == M_ACK) ? 2'b00 : 2'b01);
            if (chain) begin
                @(negedge CLK);
                SEND_BYTE = 1'b0;
            end
        end else if (mode == M_STALL) begin
            wait_cycles(half);
            got[n] = DATA_MOUSE_IN;
            mask = 11'((1 << (n + 1)) - 1);
            check_val("stall_bits", got & mask, exp_f & mask);
            wait_done(BT + 60, ok, code, dcyc);
            check_val("stall_done_seen", ok, 1);
            check_val("stall_code", code, 2'b10);
            check_val("stall_timeout_gap", ((dcyc - last_fall) >= BT) && ((dcyc - last_fall) <= BT + 5), 1);
            wait_cycles(5);
            check_val("no_second_frame", {BUSY, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 3'b000);
        end else begin
            wait_cycles(half / 2);
            check_val("busy_before_reset", BUSY, 1);
            RESET = 1'b1;
            @(posedge CLK);
            #1;
            check_val("reset_mid_frame",
                      {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT, BUSY, BYTE_SENT, BYTE_ERROR_CODE},
                      7'b0);
            @(negedge CLK);
            RESET = 1'b0;
            wait_cycles(3);
            check_val("idle_after_reset", {BUSY, BYTE_SENT}, 2'b00);
        end
    endtask

    initial begin
        logic [7:0] rb;
        int rm, rh;

        wait_cycles(4);
        check_val("reset_state",
                  {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT, BUSY, BYTE_SENT, BYTE_ERROR_CODE}, 7'b0);
        RESET = 1'b0;
        wait_cycles(3);

        // Enable-streaming command, acknowledged.
        issue_send(8'hF4);
        run_frame(8'hF4, M_ACK, 0, 10, 1'b0, 8'h00);

        // Back-to-back 0xFF then 0x00; the request in the BYTE_SENT cycle is not taken.
        issue_send(8'hFF);
        run_frame(8'hFF, M_ACK, 0, 10, 1'b1, 8'h00);
        run_frame(8'h00, M_ACK, 0, 10, 1'b0, 8'h00);

        // Mouse keeps data high during the acknowledge clock.
        issue_send(8'hF4);
        run_frame(8'hF4, M_NOACK, 0, 10, 1'b0, 8'h00);

        // Mouse never clocks.
        issue_send(8'hFF);
        run_frame(8'hFF, M_SILENT, 0, 10, 1'b0, 8'h00);

        // Mouse stops after bit3, with a stray request mid-frame.
        issue_send(8'hA6);
        run_frame(8'hA6, M_STALL, 4, 10, 1'b0, 8'h00);

        // Reset in the middle of the data bits, then a clean frame.
        issue_send(8'h3C);
        run_frame(8'h3C, M_RESET, 3, 10, 1'b0, 8'h00);
        issue_send(8'hF4);
        run_frame(8'hF4, M_ACK, 0, 10, 1'b0, 8'h00);

        // Random bytes, acknowledge outcomes and mouse clock rates.
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rm = $urandom_range(0, 1);
            rh = $urandom_range(8, 14);
            issue_send(rb);
            run_frame(rb, rm, 0, rh, 1'b0, 8'h00);
        end

        wait_cycles(5);
        check_val("byte_sent_pulses", sent_pulses, 11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mouse_transmitter.md
Name: mouse_transmitter

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (for example 0xFF reset, 0xF4 enable streaming) from the FPGA to the mouse.
- It pairs with the existing MouseReceiver and shares the same bidirectional PS/2 clock and data lines through open-drain enables at the top level.
- It performs the request-to-send sequence, shifts out the frame on device-generated clock edges, checks the device acknowledge and reports status on a one-cycle done strobe.

Parameters:
- CLK_HOLD_CYCLES, 6000, CLK cycles the host holds the mouse clock low (120 us at 50 MHz).
- DATA_SETUP_CYCLES, 50, CLK cycles data is driven low before the mouse clock is released.
- FIRST_EDGE_TIMEOUT, 750000, max CLK cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 100000, max CLK cycles between consecutive device falling edges, or until the bus goes idle (2 ms).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- CLK_MOUSE_IN  in  1  PS/2 clock line as read from the pad.
- DATA_MOUSE_IN  in  1  PS/2 data line as read from the pad.
- SEND_BYTE  in  1  request strobe; sampled only in IDLE.
- BYTE_TO_SEND  in  8  command byte; latched when SEND_BYTE is accepted.
- CLK_MOUSE_OUT_EN  out  1  1 = pull the mouse clock low.
- DATA_MOUSE_OUT  out  1  value driven on data while DATA_MOUSE_OUT_EN = 1; always 0 in this design.
- DATA_MOUSE_OUT_EN  out  1  1 = drive data with DATA_MOUSE_OUT; 0 = line released (reads 1).
- BUSY  out  1  1 in every state except IDLE.
- BYTE_SENT  out  1  one-cycle done pulse.
- BYTE_ERROR_CODE  out  2  00 = acknowledged, 01 = no acknowledge, 10 = timeout. Valid with BYTE_SENT; held until the next BYTE_SENT.

Behaviour:
- Reset, applied on the next CLK edge from any state:
  - state goes to IDLE;
  - CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT, BUSY and BYTE_SENT = 0;
  - BYTE_ERROR_CODE = 00;
  - counters = 0.
  - Reset mid-frame therefore releases both lines on the next CLK edge.
- Input synchronisation: CLK_MOUSE_IN and DATA_MOUSE_IN each pass through a 2-flop synchroniser. A falling edge is sync-clock previous = 1 and current = 0, and produces a one-cycle internal pulse.
- Parity: odd parity, computed at latch time as ~^BYTE_TO_SEND.
- IDLE:
  - Both lines are released.
  - When SEND_BYTE = 1: latch the byte and parity, clear counters, go to HOLD_CLK.
  - SEND_BYTE in any other state is ignored and does not queue.
- HOLD_CLK: CLK_MOUSE_OUT_EN = 1 for exactly CLK_HOLD_CYCLES cycles, then go to PULL_DATA.
- PULL_DATA: CLK_MOUSE_OUT_EN = 1 and DATA_MOUSE_OUT_EN = 1 (start bit 0) for DATA_SETUP_CYCLES cycles, then go to RELEASE.
- RELEASE:
  - Clock released; data still driven low.
  - The timeout counter runs.
  - First falling edge: present bit0, go to SEND_BITS with bit index 1.
  - Counter reaching FIRST_EDGE_TIMEOUT goes to ABORT.
- SEND_BITS:
  - Each falling edge presents the next frame bit: indices 1-7 give byte bits 1-7 (LSB first), index 8 gives parity, index 9 gives stop.
  - A bit value of 1 is presented as DATA_MOUSE_OUT_EN = 0; a value of 0 as DATA_MOUSE_OUT_EN = 1.
  - The stop bit is always presented as released (EN = 0). Presenting it moves to WAIT_ACK.
  - The timeout counter clears on each falling edge; reaching BIT_TIMEOUT goes to ABORT.
- WAIT_ACK:
  - Lines released.
  - On the next falling edge, sample the synced data: 0 means ack OK (code 00), 1 means no ack (code 01). Then go to WAIT_IDLE.
  - BIT_TIMEOUT applies.
- WAIT_IDLE:
  - Wait until both synced lines are 1, then assert BYTE_SENT for 1 cycle with the code and go to IDLE.
  - BIT_TIMEOUT applies and goes to ABORT.
- ABORT: release both lines, BYTE_SENT = 1 for 1 cycle with code 10, go to IDLE.
- Frame totals: 11 device falling edges are consumed after RELEASE (10 data/parity/stop, 1 ack).
- Data is changed only in the CLK cycle following a detected falling edge; it is never changed while the synced mouse clock is high.
- SEND_BYTE asserted in the same cycle as BYTE_SENT is ignored, because the state is not yet IDLE. It is accepted from the following cycle.

Test Plan:
- SEND_BYTE with 0xF4; model mouse clocks at a 80 us period and drives ack 0 → clock held low 6000 cycles, then data low. Data sampled on rising edges reads 0,0,0,1,0,1,1,1,1 with parity 0, stop 1. Then BYTE_SENT pulse, BYTE_ERROR_CODE = 00, BUSY = 0.
- Send 0xFF and then 0x00 back-to-back → parity bit 1 for both. Data bits are all 1 and all 0 respectively. Both give code 00.
- Send 0xF4; model leaves data high during the ack clock → BYTE_SENT with code 01; both lines released afterwards.
- Send 0xFF; model never clocks → BYTE_SENT with code 10 exactly FIRST_EDGE_TIMEOUT cycles after release. CLK_MOUSE_OUT_EN and DATA_MOUSE_OUT_EN = 0.
- Model stops clocking after bit3 → code 10 after BIT_TIMEOUT cycles. A pulse on SEND_BYTE during the frame is ignored: the latched byte is unchanged and no second frame follows.
- Assert RESET while in SEND_BITS → next edge: all outputs 0, BUSY = 0, no BYTE_SENT. A new SEND_BYTE of 0xF4 then completes with code 00.
